// File: rtl/sprite_pkg.sv
// Shared types for the sprite memory scheduler: colour word, requester tags, FSM states.
package sprite_pkg;

  localparam logic [23:0] TRANS_RGB = 24'hFE06FF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {TAG_MARIO, TAG_BRICK, TAG_BG} tag_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} sched_state_t;

endpackage

// File: rtl/sprite_mem_scheduler.sv
// Time-shares the sprite memory between mario, brick and background; done arrives k+2 cycles after pix_start.
// No backpressure: pix_start is taken in IDLE/DONE only, otherwise dropped and flagged in sticky overrun.
module sprite_mem_scheduler #(
  parameter int ADDR_W = 18,
  parameter int RGB_W = 24,
  parameter logic [RGB_W-1:0] TRANS_RGB = RGB_W'(sprite_pkg::TRANS_RGB)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_start,
  input  logic              mario_req,
  input  logic [ADDR_W-1:0] mario_addr,
  input  logic              brick_req,
  input  logic [ADDR_W-1:0] brick_addr,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [RGB_W-1:0]  mem_rdata,
  output logic [RGB_W-1:0]  mario_rgb,
  output logic [RGB_W-1:0]  brick_rgb,
  output logic [RGB_W-1:0]  bg_rgb,
  output logic              mario_opaque,
  output logic              brick_opaque,
  output logic              done,
  output logic              busy,
  output logic              overrun
);
  import sprite_pkg::*;

  typedef struct packed {
    logic [1:0]              k;
    tag_t [2:0]              tag;
    logic [2:0][ADDR_W-1:0]  addr;
  } rd_list_t;

  // Fixed priority: mario, brick, then background which is always fetched.
  function automatic rd_list_t build_list(input logic m_req, input logic [ADDR_W-1:0] m_addr,
                                          input logic b_req, input logic [ADDR_W-1:0] b_addr,
                                          input logic [ADDR_W-1:0] g_addr);
    rd_list_t   l;
    logic [1:0] n;
    l = '0;
    n = 2'd0;
    if (m_req) begin
      l.addr[n] = m_addr;
      l.tag[n]  = TAG_MARIO;
      n         = n + 2'd1;
    end
    if (b_req) begin
      l.addr[n] = b_addr;
      l.tag[n]  = TAG_BRICK;
      n         = n + 2'd1;
    end
    l.addr[n] = g_addr;
    l.tag[n]  = TAG_BG;
    l.k       = n + 2'd1;
    return l;
  endfunction

  sched_state_t     state, state_nxt;
  rd_list_t         lst, lst_q;
  logic [1:0]       idx;
  tag_t             issue_tag, pend_tag;
  logic             rd_pend;
  logic             lat_mario, lat_brick;
  logic [RGB_W-1:0] stg_mario, stg_brick, stg_bg;
  logic [RGB_W-1:0] stg_mario_n, stg_brick_n, stg_bg_n;
  logic             accept;

  assign lst    = build_list(mario_req, mario_addr, brick_req, brick_addr, bg_addr);
  assign accept = pix_start && (state == S_IDLE || state == S_DONE);
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: if (idx == lst_q.k) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = accept ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The last word lands in the same cycle as the commit, so commit reads through this bypass.
  always_comb begin
    stg_mario_n = stg_mario;
    stg_brick_n = stg_brick;
    stg_bg_n    = stg_bg;
    if (rd_pend) begin
      case (pend_tag)
        TAG_MARIO: stg_mario_n = mem_rdata;
        TAG_BRICK: stg_brick_n = mem_rdata;
        default:   stg_bg_n    = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      lst_q        <= '0;
      idx          <= '0;
      issue_tag    <= TAG_MARIO;
      pend_tag     <= TAG_MARIO;
      rd_pend      <= 1'b0;
      lat_mario    <= 1'b0;
      lat_brick    <= 1'b0;
      stg_mario    <= '0;
      stg_brick    <= '0;
      stg_bg       <= '0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      mario_rgb    <= '0;
      brick_rgb    <= '0;
      bg_rgb       <= '0;
      mario_opaque <= 1'b0;
      brick_opaque <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_pend   <= mem_rd;
      pend_tag  <= issue_tag;
      stg_mario <= stg_mario_n;
      stg_brick <= stg_brick_n;
      stg_bg    <= stg_bg_n;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      done      <= 1'b0;
      if (accept) begin
        lst_q     <= lst;
        lat_mario <= mario_req;
        lat_brick <= brick_req;
        mem_rd    <= 1'b1;
        mem_addr  <= lst.addr[0];
        issue_tag <= lst.tag[0];
        idx       <= 2'd1;
      end else if (state == S_ISSUE && idx != lst_q.k) begin
        mem_rd    <= 1'b1;
        mem_addr  <= lst_q.addr[idx];
        issue_tag <= lst_q.tag[idx];
        idx       <= idx + 2'd1;
      end
      if (pix_start && (state == S_ISSUE || state == S_DRAIN)) overrun <= 1'b1;
      if (state == S_DRAIN) begin
        done         <= 1'b1;
        mario_rgb    <= lat_mario ? stg_mario_n : '0;
        brick_rgb    <= lat_brick ? stg_brick_n : '0;
        bg_rgb       <= stg_bg_n;
        mario_opaque <= lat_mario && (stg_mario_n != TRANS_RGB);
        brick_opaque <= lat_brick && (stg_brick_n != TRANS_RGB);
      end
    end
  end

endmodule

// File: tb/tb_sprite_mem_scheduler.sv
// Directed bench for sprite_mem_scheduler: vector table plus back-to-back, overrun and mid-slot reset sequences.
module tb_sprite_mem_scheduler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_start;
  logic        mario_req, brick_req;
  logic [17:0] mario_addr, brick_addr, bg_addr;
  logic        mem_rd;
  logic [17:0] mem_addr;
  logic [23:0] mem_rdata;
  logic [23:0] mario_rgb, brick_rgb, bg_rgb;
  logic        mario_opaque, brick_opaque, done, busy, overrun;

  int tests = 0;
  int fails = 0;

  logic [23:0] mem [logic [17:0]];

  always #5 Clk = ~Clk;

  sprite_mem_scheduler dut (
    .Clk(Clk), .Reset(Reset), .pix_start(pix_start),
    .mario_req(mario_req), .mario_addr(mario_addr),
    .brick_req(brick_req), .brick_addr(brick_addr), .bg_addr(bg_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mario_rgb(mario_rgb), .brick_rgb(brick_rgb), .bg_rgb(bg_rgb),
    .mario_opaque(mario_opaque), .brick_opaque(brick_opaque),
    .done(done), .busy(busy), .overrun(overrun)
  );

  function automatic logic [23:0] rd_mem(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return 24'h000000;
  endfunction

  // Read data valid only in the cycle after mem_rd; filler exposes mistimed captures.
  always @(posedge Clk) mem_rdata <= mem_rd ? rd_mem(mem_addr) : 24'hDEAD00;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic                 m_req;
    logic                 b_req;
    logic [17:0]          m_addr;
    logic [17:0]          b_addr;
    logic [17:0]          g_addr;
    logic [23:0]          m_word;
    logic [23:0]          b_word;
    logic [23:0]          g_word;
    logic [1:0]           k;
    logic [2:0][17:0]     a;
    logic [23:0]          e_mrgb;
    logic                 e_mop;
    logic [23:0]          e_brgb;
    logic                 e_bop;
    logic [23:0]          e_grgb;
  } vec_t;

  vec_t vecs [6];

  task automatic set_inputs(input vec_t v);
    mario_req  = v.m_req;
    brick_req  = v.b_req;
    mario_addr = v.m_addr;
    brick_addr = v.b_addr;
    bg_addr    = v.g_addr;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic        e_rd;
    logic [17:0] e_addr;
    logic        e_done;
    mem[v.m_addr] = v.m_word;
    mem[v.b_addr] = v.b_word;
    mem[v.g_addr] = v.g_word;
    @(negedge Clk);
    set_inputs(v);
    pix_start = 1'b1;
    @(negedge Clk);
    pix_start  = 1'b0;
    mario_req  = ~v.m_req;
    brick_req  = ~v.b_req;
    mario_addr = 18'h3FFFF;
    brick_addr = 18'h3FFFE;
    bg_addr    = 18'h3FFFD;
    for (int c = 1; c <= int'(v.k) + 2; c++) begin
      e_rd   = (c <= int'(v.k));
      e_addr = e_rd ? v.a[c-1] : 18'h0;
      e_done = (c == int'(v.k) + 2);
      check($sformatf("v%0d_cyc%0d rd/addr/done", id, c), {mem_rd, mem_addr, done},
            {e_rd, e_addr, e_done});
      if (c < int'(v.k) + 2) @(negedge Clk);
    end
    check($sformatf("v%0d mario", id), {mario_rgb, mario_opaque}, {v.e_mrgb, v.e_mop});
    check($sformatf("v%0d brick", id), {brick_rgb, brick_opaque}, {v.e_brgb, v.e_bop});
    check($sformatf("v%0d bg", id), bg_rgb, v.e_grgb);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    //        mreq  breq  m_addr     b_addr     g_addr     m_word       b_word       g_word       k     a[2]       a[1]       a[0]       mario          brick          bg
    vecs[0] = {1'b1, 1'b1, 18'h01000, 18'h02000, 18'h00300, 24'h112233, 24'h445566, 24'h778899, 2'd3,
               {18'h00300, 18'h02000, 18'h01000}, 24'h112233, 1'b1, 24'h445566, 1'b1, 24'h778899};
    vecs[1] = {1'b0, 1'b0, 18'h01100, 18'h02100, 18'h00400, 24'hABCDEF, 24'h123123, 24'h5C94FC, 2'd1,
               {18'h0, 18'h0, 18'h00400}, 24'h000000, 1'b0, 24'h000000, 1'b0, 24'h5C94FC};
    vecs[2] = {1'b1, 1'b0, 18'h01200, 18'h02200, 18'h00500, 24'hFE06FF, 24'h999999, 24'h000000, 2'd2,
               {18'h0, 18'h00500, 18'h01200}, 24'hFE06FF, 1'b0, 24'h000000, 1'b0, 24'h000000};
    vecs[3] = {1'b1, 1'b0, 18'h01201, 18'h02200, 18'h00500, 24'hFE06FE, 24'h999999, 24'h000000, 2'd2,
               {18'h0, 18'h00500, 18'h01201}, 24'hFE06FE, 1'b1, 24'h000000, 1'b0, 24'h000000};
    vecs[4] = {1'b0, 1'b1, 18'h01300, 18'h02300, 18'h00600, 24'h010101, 24'hFE06FF, 24'h123456, 2'd2,
               {18'h0, 18'h00600, 18'h02300}, 24'h000000, 1'b0, 24'hFE06FF, 1'b0, 24'h123456};
    vecs[5] = {1'b0, 1'b1, 18'h01400, 18'h02400, 18'h00700, 24'h020202, 24'h000000, 24'hFFFFFF, 2'd2,
               {18'h0, 18'h00700, 18'h02400}, 24'h000000, 1'b0, 24'h000000, 1'b1, 24'hFFFFFF};

    Reset = 1'b1;
    pix_start = 1'b0;
    set_inputs(vecs[0]);
    repeat (3) @(negedge Clk);
    check("reset ctl", {mem_rd, mem_addr, done, busy, overrun}, 80'h0);
    check("reset rgb", {mario_rgb, brick_rgb, bg_rgb}, 80'h0);
    check("reset opaque", {mario_opaque, brick_opaque}, 80'h0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    check("overrun after table", overrun, 1'b0);

    // Back-to-back k=3 slots with pix_start in every DONE cycle.
    set_inputs(vecs[0]);
    pix_start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge Clk);
      pix_start = (c % 5 == 0) && (c <= 10);
      check($sformatf("b2b_cyc%0d done/rd", c), {done, mem_rd},
            {(c % 5 == 0) && (c >= 5) && (c <= 15), (c % 5 >= 1) && (c % 5 <= 3) && (c <= 13)});
    end
    check("b2b overrun", overrun, 1'b0);
    check("b2b rgb", {mario_rgb, brick_rgb, bg_rgb}, {24'h112233, 24'h445566, 24'h778899});

    // Re-pulse in cycle 2: dropped, slot completes with the originally latched addresses.
    @(negedge Clk);
    pix_start = 1'b1;
    @(negedge Clk);
    pix_start = 1'b0;
    @(negedge Clk);
    pix_start  = 1'b1;
    mario_addr = 18'h01200;
    bg_addr    = 18'h00400;
    brick_req  = 1'b0;
    @(negedge Clk);
    pix_start = 1'b0;
    check("ovr cyc3 addr", {mem_rd, mem_addr}, {1'b1, 18'h00300});
    @(negedge Clk);
    check("ovr cyc4 flag", {overrun, mem_rd}, {1'b1, 1'b0});
    @(negedge Clk);
    check("ovr cyc5 done", done, 1'b1);
    check("ovr cyc5 rgb", {mario_rgb, brick_rgb, bg_rgb}, {24'h112233, 24'h445566, 24'h778899});
    repeat (3) @(negedge Clk);
    check("ovr sticky idle", {overrun, busy, done}, {1'b1, 1'b0, 1'b0});

    // Reset (with a coincident pix_start) in cycle 2 of a slot.
    set_inputs(vecs[0]);
    pix_start = 1'b1;
    @(negedge Clk);
    pix_start = 1'b0;
    @(negedge Clk);
    Reset     = 1'b1;
    pix_start = 1'b1;
    @(negedge Clk);
    Reset     = 1'b0;
    pix_start = 1'b0;
    check("rst mid ctl", {mem_rd, mem_addr, done, busy, overrun}, 80'h0);
    check("rst mid rgb", {mario_rgb, brick_rgb, bg_rgb}, 80'h0);
    check("rst mid opaque", {mario_opaque, brick_opaque}, 80'h0);
    for (int c = 4; c <= 8; c++) begin
      @(negedge Clk);
      check($sformatf("rst_cyc%0d quiet", c), {done, busy, mem_rd}, 80'h0);
    end
    run_vec(vecs[1], 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
